// File: rtl/codec_i2c_arbiter.sv
// Round-robin arbiter sharing the WM8731 I2C write controller among NUM_REQ requesters.
// Optional codec register shadow enabled by defining CODEC_SHADOW_EN.
module codec_i2c_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int          MAX_RETRY   = 3,
  parameter int          TIMEOUT_CYC = 2_000_000
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   busy,
  output logic [23:0]            i2c_data,
  output logic                   i2c_go,
  input  logic                   i2c_end,
  input  logic                   i2c_ack,
  input  logic [3:0]             shadow_addr,
  output logic [8:0]             shadow_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_END, CHECK, RELEASE, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [15:0]        word_q, word_d;
  logic [3:0]         retry_q, retry_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               ack_q, ack_d;
  logic               reissue_q, reissue_d;
  logic               fail_q, fail_d;
  logic               go_q, go_d;
  logic [23:0]        data_q, data_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic               hi_found;
  logic [IDX_W-1:0]   hi_idx, lo_idx, pick_idx;
  logic [15:0]        hi_word, lo_word, pick_word;

  // A requester whose done is pulsing this cycle is masked so a held valid is not re-granted.
  always_comb begin
    elig     = req_valid & ~done_q;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_word  = '0;
    lo_word  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (elig[j]) begin
        lo_idx  = IDX_W'(j);
        lo_word = req_data[16*j +: 16];
        if (IDX_W'(j) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
          hi_word  = req_data[16*j +: 16];
        end
      end
    end
    pick_idx  = hi_found ? hi_idx  : lo_idx;
    pick_word = hi_found ? hi_word : lo_word;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    word_d    = word_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    ack_d     = ack_q;
    reissue_d = reissue_q;
    fail_d    = fail_q;
    go_d      = go_q;
    data_d    = data_q;
    done_d    = '0;
    err_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d   = pick_idx;
          word_d    = pick_word;
          retry_d   = '0;
          timer_d   = '0;
          reissue_d = 1'b0;
          fail_d    = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        data_d  = {DEV_ADDR, word_q};
        go_d    = 1'b1;
        timer_d = '0;
        state_d = WAIT_END;
      end
      WAIT_END: begin
        timer_d = timer_q + TMR_W'(1);
        // GO is dropped on the same edge that sees END so the controller is released promptly.
        if (i2c_end) begin
          ack_d   = i2c_ack;
          go_d    = 1'b0;
          state_d = CHECK;
        end else if (timer_q == TMR_LAST) begin
          fail_d  = 1'b1;
          go_d    = 1'b0;
          timer_d = '0;
          state_d = RELEASE;
        end
      end
      CHECK: begin
        go_d    = 1'b0;
        timer_d = '0;
        if (ack_q) begin
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 4'd1;
            reissue_d = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
        end
        state_d = RELEASE;
      end
      RELEASE: begin
        timer_d = timer_q + TMR_W'(1);
        if (!i2c_end) begin
          timer_d = '0;
          if (reissue_q) begin
            reissue_d = 1'b0;
            state_d   = ISSUE;
          end else begin
            state_d = FINISH;
          end
        end else if (timer_q == TMR_LAST) begin
          fail_d    = 1'b1;
          reissue_d = 1'b0;
          state_d   = FINISH;
        end
      end
      FINISH: begin
        for (int j = 0; j < NUM_REQ; j++) begin
          done_d[j] = (grant_q == IDX_W'(j));
          err_d[j]  = (grant_q == IDX_W'(j)) && fail_q;
        end
        rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      retry_q   <= '0;
      timer_q   <= '0;
      reissue_q <= 1'b0;
      fail_q    <= 1'b0;
      go_q      <= 1'b0;
      data_q    <= '0;
      done_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
      reissue_q <= reissue_d;
      fail_q    <= fail_d;
      go_q      <= go_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    grant_q <= grant_d;
    word_q  <= word_d;
    ack_q   <= ack_d;
  end

  assign req_done = done_q;
  assign req_err  = err_q;
  assign busy     = (state_q != IDLE);
  assign i2c_data = data_q;
  assign i2c_go   = go_q;

`ifdef CODEC_SHADOW_EN
  logic [8:0] shadow_q [10];
  logic [8:0] shadow_d [10];
  logic [8:0] rd_q, rd_d;

  // Register 15 is the codec's reset register, so writing it clears the whole shadow.
  always_comb begin
    for (int k = 0; k < 10; k++) shadow_d[k] = shadow_q[k];
    if (state_q == FINISH && !fail_q) begin
      if (word_q[15:9] == 7'd15) begin
        for (int k = 0; k < 10; k++) shadow_d[k] = '0;
      end else begin
        for (int k = 0; k < 10; k++) begin
          if (word_q[15:9] == 7'(k)) shadow_d[k] = word_q[8:0];
        end
      end
    end
    rd_d = '0;
    for (int k = 0; k < 10; k++) begin
      if (shadow_addr == 4'(k)) rd_d = shadow_q[k];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int k = 0; k < 10; k++) shadow_q[k] <= '0;
      rd_q <= '0;
    end else begin
      for (int k = 0; k < 10; k++) shadow_q[k] <= shadow_d[k];
      rd_q <= rd_d;
    end
  end

  assign shadow_data = rd_q;
`else
  logic unused_shadow_addr;
  assign unused_shadow_addr = ^shadow_addr;
  assign shadow_data        = '0;
`endif

endmodule

// File: doc/codec_i2c_arbiter.md
# codec_i2c_arbiter

- Shares the single I2C controller (WM8731 codec write path) between several register-write requesters, e.g. boot config sequencer, synth volume control and mute logic.
- Grants requesters round-robin and frames each 16-bit codec word with the device address.
- Drives the controller's level-sensitive GO/END/ACK handshake; retries on NACK and times out on a hung transfer.
- Sits between the synth control logic and `I2C_Controller`, all in the `CLOCK_50` domain.

## Interface
- `NUM_REQ`, 2: number of requester ports (1–8).
- `DEV_ADDR`, 8'h34: I2C write address prepended to every word.
- `MAX_RETRY`, 3: re-issues after NACK before error (0–15).
- `TIMEOUT_CYC`, 2_000_000: `CLOCK_50` cycles allowed per attempt for END to assert, or to deassert after GO drops.

- `CLOCK_50` in 1: system clock; only clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester write request, held until `req_done`.
- `req_data` in 16*NUM_REQ: requester i at `[16i+15:16i]`, {reg_addr[6:0], value[8:0]}, stable while `req_valid`.
- `req_done` out NUM_REQ: one-cycle pulse, transfer finished (success or error).
- `req_err` out NUM_REQ: valid with `req_done`; 1 = retries exhausted or timeout.
- `busy` out 1: high whenever state ≠ IDLE.
- `i2c_data` out 24: {DEV_ADDR, word} to controller.
- `i2c_go` out 1: GO level to controller.
- `i2c_end` in 1: END level from controller.
- `i2c_ack` in 1: controller ACK flag; 0 = all bytes acknowledged, 1 = NACK.
- `shadow_addr` in 4: shadow read index.
- `shadow_data` out 9: shadow read data.

## Operation
- States: IDLE, ISSUE, WAIT_END, CHECK, RELEASE, FINISH.
- IDLE: if any `req_valid`, grant first set bit scanning upward from `rr_ptr`, wrapping. Latch grant index and `req_data`; clear retry count and timer. Go to ISSUE.
- ISSUE: load `i2c_data`, assert `i2c_go`, go to WAIT_END.
- WAIT_END: hold `i2c_go`; timer counts up.
  - On `i2c_end`=1, sample `i2c_ack` and go to CHECK.
  - On timer = TIMEOUT_CYC-1, mark timeout and go to RELEASE.
- CHECK: deassert `i2c_go`. `i2c_ack`=0 → success. `i2c_ack`=1 and retry < MAX_RETRY → retry++, pending-reissue. Otherwise → error. Go to RELEASE.
- RELEASE: hold `i2c_go` low until `i2c_end`=0 (timer restarted, same timeout). Then go to ISSUE if pending-reissue, else FINISH.
- FINISH: pulse `req_done[grant]`, with `req_err[grant]` = error or timeout. Set `rr_ptr` = grant+1 mod NUM_REQ. Go to IDLE.
- A requester dropping `req_valid` mid-transfer does not abort it; done still pulses.
- Same data may be re-requested immediately; it is not granted before the cycle after `req_done`.
- Retry count width: 4 bits. Timer width: $clog2(TIMEOUT_CYC)+1.

## Timing
- Reset values: `i2c_go`=0, `i2c_data`=0, `req_done`=0, `req_err`=0, `busy`=0, `rr_ptr`=0, state IDLE, shadow all 0.
- `reset` mid-transfer: `i2c_go` is low the cycle after the reset edge and the pending request is dropped without `req_done`. Requesters must re-request.
- Grant: `req_valid` sampled in IDLE → `i2c_go` high 2 cycles later (IDLE→ISSUE registers, GO registered).
- `i2c_end` high observed → `i2c_go` low the next cycle.
- `i2c_end` low observed in RELEASE → `req_done` pulses 2 cycles later (FINISH) when no retry.
- `i2c_end`/`i2c_ack` are sampled directly. The controller's divided clock is derived from `CLOCK_50`, so levels are stable for many cycles; no synchronizer is required.
- Only one transfer is outstanding at a time; `i2c_data` is constant from ISSUE through RELEASE.

## Configuration
- `CODEC_SHADOW_EN` defined:
  - Holds a 10×9-bit shadow of codec regs 0–9.
  - On each successful transfer whose reg_addr < 10, the shadow entry is updated in FINISH.
  - `shadow_data` = entry[`shadow_addr`], registered, 1-cycle latency; index ≥10 reads 0.
  - Writes to reg 15 (reset) clear all entries.
- Not defined: no shadow storage; `shadow_data` tied 0; `shadow_addr` ignored.

## Test plan
- Single write: req0 word 16'h0C00, controller model ACKs → `i2c_data`=24'h340C00, one GO/END cycle, `req_done[0]`=1, `req_err[0]`=0.
- Contention: req0 and req1 asserted same cycle with rr_ptr=0 → req0 served, then req1. With both re-asserted, req1's next grant precedes req0's (round-robin).
- NACK retry: model NACKs twice then ACKs, MAX_RETRY=3 → 3 GO pulses, `req_err`=0. NACK 4 times → 4 GO pulses, `req_err`=1.
- Timeout: model never raises END, TIMEOUT_CYC=100 → `i2c_go` drops at cycle 100 of WAIT_END, `req_done`+`req_err` pulse after END seen low.
- Reset mid-transfer: `reset` during WAIT_END → `i2c_go`=0 next cycle, no `req_done`, `busy`=0.
- Shadow (`CODEC_SHADOW_EN`): write 16'h0477 then read `shadow_addr`=2 → 9'h077. Write 16'h1E00 → all entries read 0.
